serial_word_aligner: RTL
========================

# serial_word_aligner

Upstream stage of the IDLE detector. Takes the raw serial bit stream at clk_32f, finds the 8-bit word boundary from the comma symbol 0xBC, confirms lock after a run of aligned commas, and then presents aligned parallel words with a one-cycle strobe. Its data_out/word_valid pair drives the IDL input of the IDLE detector.

## Interface

- COMMA, 8'hBC, alignment symbol.
- SYNC_COUNT, 4, consecutive aligned commas required for lock (range 2–15).
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  1  serial data, MSB of each word first.
- data_out  output  8  last aligned word; held between strobes.
- word_valid  output  1  one-cycle pulse when data_out updates.
- is_comma  output  1  data_out == COMMA; qualified by word_valid.
- active  output  1  alignment locked.

## Operation

- Shift register: shreg <= {shreg[6:0], data_in} on every clk_32f edge, in all states.
- Bit counter bit_cnt[2:0] wraps 7→0. Word boundary = cycle with bit_cnt==7 while in ALIGN/ACTIVE. At that cycle shreg holds a complete aligned word.
- Comma counter bc_cnt[3:0].
- States:
  - HUNT: reset state. Compare shreg to COMMA every cycle. On match: bc_cnt<=1, bit_cnt<=0, go to ALIGN.
  - ALIGN: bit_cnt increments every cycle. At a boundary with shreg==COMMA: bc_cnt<=bc_cnt+1. When bc_cnt+1==SYNC_COUNT, go to ACTIVE. At a boundary with shreg!=COMMA: bc_cnt<=0, go to HUNT. Commas at non-boundary positions are ignored.
  - ACTIVE: at every boundary, data_out<=shreg and word_valid<=1 for the following cycle. is_comma<=(shreg==COMMA). Commas and data pass through alike; no loss-of-lock detection. Only reset leaves ACTIVE.
- The active output is high exactly while state==ACTIVE (registered).
- data_out and is_comma never change outside a word_valid cycle.

## Timing

- Reset values: data_out=0, word_valid=0, is_comma=0, active=0. Internal state: state=HUNT, shreg=0, bit_cnt=0, bc_cnt=0.
- Asserting reset_L low mid-operation clears all of the above immediately, without waiting for a clock edge. The block restarts in HUNT after release.
- Lock latency: first comma matched in shreg at cycle t. Aligned commas follow at t+8, t+16, …, t+8·(SYNC_COUNT−1). active rises at t+8·(SYNC_COUNT−1)+1; for SYNC_COUNT=4 that is t+25.
- Data latency: the last bit of a word is sampled at edge e. It is in shreg after e, the boundary is decided at e+1, and data_out/word_valid are visible after e+1. That is 2 edges total.
- word_valid period in ACTIVE is exactly 8 cycles and never back-to-back.
- The boundary that completes lock produces no word_valid. The first strobe comes at the next boundary, 8 cycles later.
- A spurious 0xBC pattern straddling two words while in HUNT starts ALIGN at the wrong phase. The next non-comma boundary returns to HUNT with bc_cnt=0.

## Structure

- Shared package holds: COMMA 8'hBC, IDLE 8'h7C, and the state encoding HUNT/ALIGN/ACTIVE as a 2-bit typedef.
- One sub-module is natural: serial_shift8, an 8-bit MSB-first shift register with async active-low clear. The alignment FSM, counters and output registers stay in serial_word_aligner.
- Expected size: 150–250 lines of RTL.

## Test plan

- Reset: hold reset_L=0 for 3 edges, then drop reset_L mid-stream while active=1. All outputs must go to 0 without a clock edge, and state must return to HUNT.
- Clean lock: 3 random bits, then 4×0xBC, then 0x7C, 0x12. active must rise 25 cycles after the first comma is in shreg. The next strobes must give data_out=0x7C (is_comma=0), then 0x12, spaced 8 cycles apart.
- Broken run: 3×0xBC, then 0x55, then 4×0xBC. The block must return to HUNT at the 0x55 boundary, with bc_cnt=0. Lock comes only after the second comma run, and no word_valid appears before it.
- Phase search: the stream is offset by 5 bits (5 filler bits, then commas). The aligner must lock on the correct phase, and the data word 0xA3 must emerge intact.
- Pass-through: after lock, send 0xBC, 0x7C, 0xBC. Expect three word_valid pulses with is_comma=1,0,1 and active staying 1.

Source files
------------

// File: rtl/serial_word_aligner_pkg.sv
// Shared constants and state encoding for the serial word aligner.
package serial_word_aligner_pkg;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;
    localparam int unsigned BC_CNT_W  = 4;

    localparam logic [WORD_W-1:0] COMMA = 8'hBC;
    localparam logic [WORD_W-1:0] IDLE  = 8'h7C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // True when a parallel word is the alignment comma.
    function automatic logic is_comma_word(input logic [WORD_W-1:0] w);
        return (w == COMMA);
    endfunction

endpackage

// File: rtl/serial_word_aligner_shift8.sv
// 8-bit MSB-first serial-in shift register with async active-low clear.
module serial_word_aligner_shift8
    import serial_word_aligner_pkg::*;
(
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [WORD_W-1:0] q
);

    // Shift one new bit in at the LSB every edge; oldest bit falls off the MSB.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            q <= '0;
        end else begin
            q <= {q[WORD_W-2:0], data_in};
        end
    end

endmodule

// File: rtl/serial_word_aligner.sv
// Finds the 8-bit word boundary from comma symbols in a serial stream,
// declares lock after SYNC_COUNT aligned commas, then strobes aligned words.
module serial_word_aligner
    import serial_word_aligner_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset_L,
    input  logic              data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              word_valid,
    output logic              is_comma,
    output logic              active
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);
    localparam logic [BC_CNT_W-1:0]  LOCK_CNT = BC_CNT_W'(SYNC_COUNT);

    state_t               state;
    logic [WORD_W-1:0]    shreg;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BC_CNT_W-1:0]  bc_cnt;
    logic [BC_CNT_W-1:0]  bc_cnt_inc;
    logic                 boundary;
    logic                 shreg_comma;

    serial_word_aligner_shift8 u_shift8 (
        .clk_32f (clk_32f),
        .reset_L (reset_L),
        .data_in (data_in),
        .q       (shreg)
    );

    assign boundary    = (bit_cnt == LAST_BIT);
    assign shreg_comma = is_comma_word(shreg);
    assign bc_cnt_inc  = bc_cnt + BC_CNT_W'(1);

    // Alignment FSM, counters and registered outputs.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= HUNT;
            bit_cnt    <= '0;
            bc_cnt     <= '0;
            data_out   <= '0;
            word_valid <= 1'b0;
            is_comma   <= 1'b0;
            active     <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            case (state)
                HUNT: begin
                    // Any bit phase may hold the comma; it defines the boundary.
                    if (shreg_comma) begin
                        bc_cnt  <= BC_CNT_W'(1);
                        bit_cnt <= '0;
                        state   <= ALIGN;
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (boundary) begin
                        if (shreg_comma) begin
                            bc_cnt <= bc_cnt_inc;
                            if (bc_cnt_inc == LOCK_CNT) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            bc_cnt <= '0;
                            state  <= HUNT;
                        end
                    end
                end
                ACTIVE: begin
                    // Locked: every boundary word passes through, commas included.
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                    if (boundary) begin
                        data_out   <= shreg;
                        word_valid <= 1'b1;
                        is_comma   <= shreg_comma;
                    end
                end
                default: begin
                    state  <= HUNT;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
